// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in/serial-out transmitter. It takes a WIDTH-bit word
//             over a valid/ready handshake and drives it one bit per clock.
//             Back-to-back words are sent with no idle gap.
//  Options  : SERIALIZER_PARITY_EN adds one even-parity bit after each word.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
`ifdef SERIALIZER_PARITY_EN
        S_PARITY = 2'b10,
`endif
        S_SHIFT  = 2'b01
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_out;
`ifdef SERIALIZER_PARITY_EN
    logic               r_parity;
`endif

    logic               w_accept;
    logic               w_last;
    logic               w_done;
    logic               w_first_in;
    logic               w_first_sh;
    logic [WIDTH-1:0]   w_rest_in;
    logic [WIDTH-1:0]   w_rest_sh;

    // The first bit goes straight to the output flop; the shift register
    // keeps only the bits still to be sent.
    assign w_first_in = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign w_rest_in  = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
    assign w_first_sh = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_rest_sh  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

    assign w_last = (r_count == c_last);

`ifdef SERIALIZER_PARITY_EN
    assign w_done = (r_state == S_PARITY);
`else
    assign w_done = (r_state == S_SHIFT) && w_last;
`endif

    assign load_ready = ((r_state == S_IDLE) || w_done) && !clear;
    assign w_accept   = load_valid && load_ready;

    assign out       = r_out;
    assign out_valid = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last) begin
`ifdef SERIALIZER_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = w_accept ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                w_next = w_accept ? S_SHIFT : S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_shreg  <= '0;
            r_out    <= IDLE_LEVEL;
`ifdef SERIALIZER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // Accept only happens in IDLE or the final cycle of a frame.
            if (w_accept) begin
                r_count  <= '0;
                r_shreg  <= w_rest_in;
                r_out    <= w_first_in;
`ifdef SERIALIZER_PARITY_EN
                r_parity <= ^data_in;
`endif
            end else if (r_state == S_SHIFT) begin
                if (!w_last) begin
                    r_count <= r_count + c_one;
                    r_shreg <= w_rest_sh;
                    r_out   <= w_first_sh;
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    r_count <= r_count + c_one;
                    r_out   <= r_parity;
`else
                    r_count <= '0;
                    r_out   <= IDLE_LEVEL;
`endif
                end
            end else begin
                r_count <= '0;
                r_out   <= IDLE_LEVEL;
            end
        end
    end

endmodule
`default_nettype wire
